// File: rtl/trigger_readout_pkg.sv
// Shared types and constants for the trigger event readout framer.
package trigger_readout_pkg;

    localparam int CNT_WIDTH = 16;

    localparam logic [1:0] TAG_HEADER  = 2'b10;
    localparam logic [1:0] TAG_TRAILER = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        FETCH   = 3'd2,
        CAPTURE = 3'd3,
        SEND    = 3'd4,
        TRAILER = 3'd5
    } state_e;

endpackage

// File: rtl/trigger_event_readout.sv
// Drains the trigger event FIFO and emits header / payload / trailer frames
// on a valid/ready stream; frames close on size limit, idle timeout or disable.
module trigger_event_readout
    import trigger_readout_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int MAX_WORDS  = 256,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  FIFO_Empty,
    input  logic [DATA_WIDTH-1:0] FIFO_Q,
    output logic                  FIFO_RE,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic                  Out_Valid,
    output logic                  Out_Last,
    input  logic                  Out_Ready,
    output logic                  Busy,
    output logic [CNT_WIDTH-1:0]  Frame_Seq,
    output logic                  Overflow_Err
);

    localparam int                   TMO_W     = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_WORDS);
    localparam logic                 CNT_TRUNC = (MAX_WORDS > 65535);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    seq_q, seq_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]    cnt_inc_s;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    ovf_q, ovf_d;
    logic                    re_s;

    assign cnt_inc_s = cnt_q + CNT_WIDTH'(1);

    // Next-state, counters and registered stream outputs.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        hold_d  = hold_q;
        ovf_d   = ovf_q;
        re_s    = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (Enable && !FIFO_Empty) begin
                    state_d = HEADER;
                end else begin
                    state_d = IDLE;
                end
            end
            HEADER: begin
                if (Out_Ready) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = FETCH;
                end else begin
                    state_d = HEADER;
                end
            end
            FETCH: begin
                // An empty-count frame never closes here: a header always gets a payload word.
                if (!FIFO_Empty) begin
                    re_s    = 1'b1;
                    state_d = CAPTURE;
                end else if ((cnt_q != '0) && ((tmo_q == TMO_LAST) || !Enable)) begin
                    state_d = TRAILER;
                end else if (tmo_q != TMO_LAST) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end else begin
                    tmo_d = tmo_q;
                end
            end
            CAPTURE: begin
                hold_d  = FIFO_Q;
                state_d = SEND;
            end
            SEND: begin
                if (Out_Ready) begin
                    cnt_d = cnt_inc_s;
                    tmo_d = '0;
                    if ((cnt_inc_s == MAX_CNT) || !Enable) begin
                        state_d = TRAILER;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            TRAILER: begin
                if (Out_Ready) begin
                    seq_d   = seq_q + CNT_WIDTH'(1);
                    ovf_d   = ovf_q | CNT_TRUNC;
                    state_d = IDLE;
                end else begin
                    state_d = TRAILER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output word follows the state being entered so it is stable while held.
        case (state_d)
            HEADER: begin
                valid_d = 1'b1;
                data_d  = {TAG_HEADER, seq_d};
            end
            SEND: begin
                valid_d = 1'b1;
                data_d  = hold_d;
            end
            TRAILER: begin
                valid_d = 1'b1;
                last_d  = 1'b1;
                data_d  = {TAG_TRAILER, cnt_d};
            end
            default: begin
                data_d = data_q;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            seq_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign FIFO_RE      = re_s & ~Reset;
    assign Out_Data     = data_q;
    assign Out_Valid    = valid_q;
    assign Out_Last     = last_q;
    assign Busy         = (state_q != IDLE);
    assign Frame_Seq    = seq_q;
    assign Overflow_Err = ovf_q;

endmodule

// File: tb/tb_trigger_event_readout.sv
// Self-checking bench: directed cycle table, timeout / disable / reset sequences,
// and randomized bursts against a frame-level reference model.
module tb_trigger_event_readout;

    localparam int MAXW = 4;
    localparam int TMO  = 8;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        FIFO_Empty = 1'b1;
    logic [17:0] FIFO_Q = 18'h0;
    logic        FIFO_RE;
    logic [17:0] Out_Data;
    logic        Out_Valid;
    logic        Out_Last;
    logic        Out_Ready;
    logic        Busy;
    logic [15:0] Frame_Seq;
    logic        Overflow_Err;

    always #5 Clock = ~Clock;

    trigger_event_readout #(
        .DATA_WIDTH(18),
        .MAX_WORDS (MAXW),
        .TIMEOUT   (TMO)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Enable      (Enable),
        .FIFO_Empty  (FIFO_Empty),
        .FIFO_Q      (FIFO_Q),
        .FIFO_RE     (FIFO_RE),
        .Out_Data    (Out_Data),
        .Out_Valid   (Out_Valid),
        .Out_Last    (Out_Last),
        .Out_Ready   (Out_Ready),
        .Busy        (Busy),
        .Frame_Seq   (Frame_Seq),
        .Overflow_Err(Overflow_Err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO model: Q is valid the cycle after a read strobe.
    logic [17:0] fifo[$];
    logic [17:0] push_req[$];
    logic        re_pend = 1'b0;

    always @(negedge Clock) re_pend <= FIFO_RE;

    always @(posedge Clock) begin
        if (re_pend && (fifo.size() > 0)) FIFO_Q <= fifo.pop_front();
        while (push_req.size() > 0) fifo.push_back(push_req.pop_front());
        FIFO_Empty <= (fifo.size() == 0);
    end

    // Stream monitor: hold-stability, scoreboard and strobe/payload counters.
    logic [18:0] exp_q[$];
    bit          sb_on = 1'b0;
    int          re_cnt = 0;
    int          pay_cnt = 0;
    logic        pv = 1'b0;
    logic [17:0] pd = 18'h0;

    always @(negedge Clock) begin
        if (Reset) begin
            pv <= 1'b0;
        end else begin
            if (pv) begin
                check("hold_valid", Out_Valid, 1);
                check("hold_data", Out_Data, pd);
            end
            pv <= Out_Valid && !Out_Ready;
            pd <= Out_Data;
            if (sb_on && FIFO_RE) re_cnt <= re_cnt + 1;
            if (sb_on && Out_Valid && Out_Ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_extra: got 0x%0h expected no word", {Out_Last, Out_Data});
                end else begin
                    check("stream", {Out_Last, Out_Data}, exp_q.pop_front());
                    if (Out_Data[17:16] == 2'b00) pay_cnt <= pay_cnt + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Reference model: split queued words into frames of at most MAXW.
    int model_seq = 0;

    task automatic expect_frames(input logic [17:0] words[$]);
        int n = words.size();
        for (int i = 0; i < n; i += MAXW) begin
            int chunk = ((n - i) < MAXW) ? (n - i) : MAXW;
            exp_q.push_back({1'b0, 2'b10, 16'(model_seq)});
            for (int k = 0; k < chunk; k++) exp_q.push_back({1'b0, words[i + k]});
            exp_q.push_back({1'b1, 2'b11, 16'(chunk)});
            model_seq = (model_seq + 1) % 65536;
        end
    endtask

    task automatic drain(input string name, input int n, input int pct);
        int r0 = re_cnt;
        int p0 = pay_cnt;
        bit done = 1'b0;
        sb_on = 1'b1;
        for (int c = 0; c < 3000 && !done; c++) begin
            tick();
            Out_Ready = ($urandom_range(0, 99) < pct);
            done = (exp_q.size() == 0) && !Busy;
        end
        check({name, "_done"}, done, 1);
        check({name, "_left"}, exp_q.size(), 0);
        tick();
        check({name, "_re"}, re_cnt - r0, n);
        check({name, "_pay"}, pay_cnt - p0, n);
        sb_on = 1'b0;
        Out_Ready = 1'b1;
        exp_q.delete();
    endtask

    task automatic run_burst(input string name, input int n, input int pct);
        logic [17:0] words[$];
        for (int i = 0; i < n; i++) begin
            logic [17:0] w;
            w = {2'b00, 16'($urandom)};
            words.push_back(w);
            push_req.push_back(w);
        end
        expect_frames(words);
        drain(name, n, pct);
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        v;
        logic [17:0] d;
        logic        l;
        logic        re;
        logic        b;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input logic en, input logic rdy, input logic v, input logic [17:0] d,
                                input logic l, input logic re, input logic b);
        vec_t t;
        t.en = en; t.rdy = rdy; t.v = v; t.d = d; t.l = l; t.re = re; t.b = b;
        tv.push_back(t);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [17:0] basic[3];
        basic[0] = 18'h00011;
        basic[1] = 18'h00022;
        basic[2] = 18'h00033;

        Reset = 1'b1;
        Enable = 1'b0;
        Out_Ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", Out_Valid, 0);
        check("rst_data", Out_Data, 0);
        check("rst_last", Out_Last, 0);
        check("rst_re", FIFO_RE, 0);
        check("rst_busy", Busy, 0);
        check("rst_seq", Frame_Seq, 0);
        check("rst_ovf", Overflow_Err, 0);
        Reset = 1'b0;
        tick();

        // Basic frame, cycle by cycle.
        add(1'b1, 1'b1, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 18'h20000, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            add(1'b1, 1'b1, 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
            add(1'b1, 1'b1, 1'b0, 18'h0, 1'b0, 1'b0, 1'b1);
            add(1'b1, 1'b1, 1'b1, basic[k], 1'b0, 1'b0, 1'b1);
        end
        for (int k = 0; k < TMO; k++) add(1'b1, 1'b1, 1'b0, 18'h0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 18'h30003, 1'b1, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++) push_req.push_back(basic[k]);
        tick();
        for (int i = 0; i < tv.size(); i++) begin
            Enable = tv[i].en;
            Out_Ready = tv[i].rdy;
            #1;
            check($sformatf("vec%0d_valid", i), Out_Valid, tv[i].v);
            check($sformatf("vec%0d_last", i), Out_Last, tv[i].l);
            check($sformatf("vec%0d_re", i), FIFO_RE, tv[i].re);
            check($sformatf("vec%0d_busy", i), Busy, tv[i].b);
            if (tv[i].v) check($sformatf("vec%0d_data", i), Out_Data, tv[i].d);
            tick();
        end
        check("basic_seq", Frame_Seq, 1);
        model_seq = 1;

        // Timeout: one word, then exactly TMO empty fetch cycles before the trailer.
        begin
            int  empty_fetch = 0;
            bit  sent = 1'b0;
            bit  got_tr = 1'b0;
            push_req.push_back(18'h00ABC);
            for (int c = 0; c < 60 && !got_tr; c++) begin
                tick();
                if (Out_Valid && Out_Last) got_tr = 1'b1;
                else if (Out_Valid && Out_Data[17:16] == 2'b10) check("tmo_header", Out_Data, 18'h20001);
                else if (Out_Valid && Out_Data == 18'h00ABC) sent = 1'b1;
                else if (sent && Busy && !Out_Valid && !FIFO_RE) empty_fetch++;
            end
            check("tmo_trailer_seen", got_tr, 1);
            check("tmo_empty_cycles", empty_fetch, TMO);
            check("tmo_trailer", Out_Data, 18'h30001);
            tick();
            check("tmo_idle", Busy, 0);
            model_seq = 2;
        end

        // Size limit: 10 words -> 4 + 4 + 2 (last closed by timeout).
        run_burst("size", 10, 100);
        check("size_seq", Frame_Seq, 16'(model_seq));

        // Random bursts with backpressure.
        for (int b = 0; b < 6; b++) run_burst($sformatf("rand%0d", b), $urandom_range(1, 11), 70);
        check("rand_seq", Frame_Seq, 16'(model_seq));

        // Disable in the cycle after the read strobe.
        begin
            bit seen = 1'b0;
            int extra_re = 0;
            push_req.push_back(18'h00101);
            push_req.push_back(18'h00102);
            push_req.push_back(18'h00103);
            Out_Ready = 1'b1;
            Enable = 1'b1;
            for (int c = 0; c < 40 && !seen; c++) begin
                tick();
                seen = FIFO_RE;
            end
            check("dis_re_seen", seen, 1);
            tick();
            Enable = 1'b0;
            tick();
            check("dis_send_valid", Out_Valid, 1);
            check("dis_send_data", Out_Data, 18'h00101);
            tick();
            check("dis_trailer_data", Out_Data, 18'h30001);
            check("dis_trailer_last", Out_Last, 1);
            check("dis_busy_hi", Busy, 1);
            tick();
            check("dis_busy_lo", Busy, 0);
            for (int c = 0; c < 10; c++) begin
                if (FIFO_RE) extra_re++;
                tick();
            end
            check("dis_no_re", extra_re, 0);
            check("dis_fifo_left", fifo.size(), 2);
            fifo.delete();
            tick();
            tick();
        end

        // Reset while holding a payload word.
        begin
            bit held = 1'b0;
            logic [17:0] w[$];
            Out_Ready = 1'b0;
            push_req.push_back(18'h00201);
            push_req.push_back(18'h00202);
            Enable = 1'b1;
            for (int c = 0; c < 40 && !held; c++) begin
                tick();
                if (Out_Valid && Out_Data[17:16] == 2'b10) Out_Ready = 1'b1;
                else Out_Ready = 1'b0;
                held = Out_Valid && (Out_Data == 18'h00201);
            end
            check("rs_held", held, 1);
            Out_Ready = 1'b0;
            Reset = 1'b1;
            tick();
            check("rs_valid", Out_Valid, 0);
            check("rs_data", Out_Data, 0);
            check("rs_last", Out_Last, 0);
            check("rs_re", FIFO_RE, 0);
            check("rs_busy", Busy, 0);
            check("rs_seq", Frame_Seq, 0);
            Reset = 1'b0;
            model_seq = 0;
            w.push_back(18'h00202);
            expect_frames(w);
            drain("rs_after", 1, 100);
            check("rs_ovf", Overflow_Err, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
